// File: rtl/cpu_pkg.sv
// cpu_pkg: seven-segment codes, decimal display limit and display FSM state type
package cpu_pkg;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [15:0][6:0] SEG = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
    7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };
  localparam logic [31:0] DEC_MAX = 32'd99_999_999;
  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_COMMIT} disp_state_e;
endpackage

// File: rtl/gpio_hex_display_hexdriver.sv
// hexdriver: combinational nibble to active-low gfedcba segment decoder (nib_i -> seg_o)
module hexdriver
  import cpu_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);
  assign seg_o = SEG[nib_i];
endmodule

// File: rtl/gpio_hex_display.sv
// gpio_hex_display: latches CPU display writes, converts to BCD or hex, drives HEX0..HEX7
// Ports: clk/rst_n, wr_en/wr_data capture, busy/done/overflow status, HEX0..HEX7 active-low segments.
module gpio_hex_display
  import cpu_pkg::*;
#(
  parameter int DECIMAL  = 1,
  parameter int BLANK_LZ = 1,
  parameter int NDIG     = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3,
  output logic [6:0]  HEX4,
  output logic [6:0]  HEX5,
  output logic [6:0]  HEX6,
  output logic [6:0]  HEX7
);
  if (NDIG != 8) begin : g_bad_ndig
    $error("gpio_hex_display supports NDIG=8 only");
  end
  disp_state_e state_q, state_d;
  logic [31:0] bin_q, bin_d, bcd_q, bcd_d, adj, src;
  logic [4:0] cnt_q, cnt_d;
  logic ovf_pend_q, ovf_pend_d, busy_q, done_q, ovf_q, commit;
  logic [8:0] lz;
  logic [6:0] seg [8];
  logic [6:0] hex_d [8];
  logic [6:0] hex_q [8];
  assign commit = state_q == ST_COMMIT;
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < 8; i++)
      adj[4*i +: 4] = bcd_q[4*i +: 4] >= 4'd5 ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
  end
  // a write always wins: it restarts any conversion, while a commit in flight still lands
  always_comb begin
    state_d = state_q;
    bin_d = bin_q;
    bcd_d = bcd_q;
    cnt_d = cnt_q;
    ovf_pend_d = ovf_pend_q;
    if (wr_en) begin
      bin_d = wr_data;
      bcd_d = '0;
      cnt_d = '0;
      ovf_pend_d = DECIMAL != 0 && wr_data > DEC_MAX;
      state_d = DECIMAL != 0 ? ST_SHIFT : ST_COMMIT;
    end else if (state_q == ST_SHIFT) begin
      {bcd_d, bin_d} = {adj, bin_q} << 1;
      cnt_d = cnt_q + 5'd1;
      state_d = cnt_q == 5'd31 ? ST_COMMIT : ST_SHIFT;
    end else if (commit) begin
      state_d = ST_IDLE;
    end
  end
  assign src = DECIMAL != 0 ? bcd_q : bin_q;
  // lz[i]: digit i and everything above it are zero; HEX0 is never blanked
  always_comb begin
    lz = 9'h100;
    for (int i = 7; i >= 1; i--) lz[i] = lz[i+1] && src[4*i +: 4] == 4'd0;
  end
  for (genvar g = 0; g < 8; g++) begin : g_dig
    hexdriver u_hex (.nib_i(src[4*g +: 4]), .seg_o(seg[g]));
    assign hex_d[g] = ovf_pend_q ? SEG_DASH : (BLANK_LZ != 0 && lz[g]) ? SEG_BLANK : seg[g];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      ovf_pend_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      ovf_q <= 1'b0;
      hex_q <= '{0: SEG[0], default: SEG_BLANK};
    end else begin
      state_q <= state_d;
      bin_q <= bin_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      busy_q <= state_d != ST_IDLE;
      done_q <= commit;
      if (commit) begin
        hex_q <= hex_d;
        ovf_q <= ovf_pend_q;
      end
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign overflow = ovf_q;
  assign HEX0 = hex_q[0];
  assign HEX1 = hex_q[1];
  assign HEX2 = hex_q[2];
  assign HEX3 = hex_q[3];
  assign HEX4 = hex_q[4];
  assign HEX5 = hex_q[5];
  assign HEX6 = hex_q[6];
  assign HEX7 = hex_q[7];
endmodule

// File: doc/gpio_hex_display.md
Name: gpio_hex_display

Overview:
- Output stage downstream of the CPU's GPIO write-back port.
- Captures each 32-bit value the CPU writes to its display I/O register (io2_out, strobed by GPIO_we_WB).
- Converts the value to decimal BCD with a sequential shift-add-3 (double-dabble) engine, or passes it through as hex.
- Drives the eight active-low seven-segment outputs HEX0..HEX7 on the board top.

Parameters:
- DECIMAL, 1: 1 = show the unsigned decimal value; 0 = show raw hex nibbles.
- BLANK_LZ, 1: 1 = blank leading zero digits. HEX0 is never blanked.
- NDIG, 8: number of displayed digits. Fixed at 8; the parameter exists for documentation and asserts only.

Ports:
- clk, input, 1: system clock (CLOCK_50 domain).
- rst_n, input, 1: asynchronous active-low reset (KEY[0]).
- wr_en, input, 1: write strobe from CPU (GPIO_we_WB).
- wr_data, input, 32: value written (io2_out).
- busy, output, 1: conversion in progress.
- done, output, 1: one-cycle pulse when the HEX outputs update.
- overflow, output, 1: latched value is >99,999,999 (decimal mode only).
- HEX0..HEX7, output, 7 each: segments {g,f,e,d,c,b,a}, active-low. HEX0 is the least significant digit.

Behaviour:
- Reset, asynchronous on rst_n=0:
  - state=IDLE, busy=0, done=0, overflow=0.
  - HEX0=7'b1000000 ("0"); HEX1..HEX7=7'b1111111 (blank).
- States: IDLE, SHIFT, COMMIT.
- IDLE, on an edge with wr_en=1:
  - Latch wr_data into the binary shift register; clear the 32-bit BCD register; count=0.
  - Set ovf_pending = (wr_data > 32'd99_999_999).
  - Go to SHIFT if DECIMAL=1, else go to COMMIT.
- SHIFT, each edge:
  - For every BCD nibble >=5, add 3.
  - Then shift {bcd, bin} left by 1 and increment count.
  - After the 32nd shift (count==31 at the edge), go to COMMIT.
- COMMIT, one edge:
  - Update HEX0..HEX7 from the BCD register (decimal) or the latched nibbles (hex).
  - overflow <= ovf_pending; done <= 1; go to IDLE.
- Latency, with the capture edge as E0:
  - Decimal: HEX and done change at E33, 33 cycles after E0.
  - Hex: HEX and done change at E1.
- busy=1 from after E0 through the COMMIT edge. Equivalently, busy = (state != IDLE), registered.
- done is high for exactly one cycle after COMMIT. It is cleared on the next edge.
- Overflow: if ovf_pending, all eight digits show dash 7'b0111111 and overflow=1. A later in-range write clears overflow at its COMMIT.
- Leading-zero blanking (BLANK_LZ=1):
  - Digits above the most significant nonzero digit show 7'b1111111.
  - Value 0 shows "0" on HEX0 only.
- HEX outputs hold their previous value throughout a conversion; no intermediate values are ever visible.
- wr_en while busy (SHIFT or COMMIT edge): restart.
  - Re-latch the new wr_data, count=0, state=SHIFT (or COMMIT in hex mode).
  - The pending conversion is discarded, no done is generated for it, and the latest write wins.
- wr_en on the same edge as COMMIT: the commit completes (HEX update, done=1) and the new value is captured. This is IDLE-equivalent capture in the same edge, and busy stays 1.
- Reset mid-conversion: abort immediately; all outputs return to reset values.
- Segment code (active-low, gfedcba):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110

Decomposition:
- Shared package cpu_pkg:
  - seven-segment constants SEG_BLANK, SEG_DASH, and the SEG table for 0..F;
  - DEC_MAX = 32'd99_999_999;
  - the display state enum typedef.
- One sub-module, hexdriver: a pure combinational 4-bit-to-7-segment decoder. It is instantiated 8 times; the blank/dash mux sits in the parent.

Test Plan:
- Reset with rst_n=0 for 1 cycle, then release -> HEX0=1000000, HEX1..7=1111111, busy=0, done=0.
- DECIMAL=1, wr_en pulse with wr_data=2 -> busy high for 33 cycles; done pulses at E33; HEX0=0100100; HEX1..7 blank.
- DECIMAL=1, wr_data=32'd12345678 -> HEX7..HEX0 = 1,2,3,4,5,6,7,8 codes; overflow=0. Then wr_data=32'd100000000 -> all digits 0111111, overflow=1.
- Restart: write 32'd5, then at E10 write 32'd907 -> exactly one done, at 33 cycles after the second write; HEX2..0 = 9,0,7; HEX3..7 blank; HEX never shows 5.
- DECIMAL=0, wr_data=32'hDEADBEEF -> done at E1; HEX7..0 = d,E,A,d,b,E,E,F.
- Assert rst_n=0 at E15 of a conversion of 32'd42 -> outputs at reset values immediately; no done; no update after release.
